// File: rtl/ball_engine.sv
// Steps NUM_BALLS balls on each frame tick, probing the obstacle RAM and emitting erase/draw pixel writes.
// Latency: 8 cycles per live ball per tick (1 cycle per dead ball); no backpressure, writes are single-cycle pulses.
module ball_engine #(
    parameter int NUM_BALLS    = 2,
    parameter int X_W          = 8,
    parameter int Y_W          = 7,
    parameter int COLOR_W      = 3,
    parameter int START_Y      = 30,
    parameter int X_MIN        = 15,
    parameter int X_MAX        = 65,
    parameter int BALL_SPACING = 20,
    parameter int LIMIT0       = 1500000,
    parameter int LIMIT1       = 1000000,
    parameter int LIMIT2       = 750000,
    parameter int LIMIT3       = 250000,
    parameter int TIMER_W      = 26,
    parameter int SCORE_DIV    = 6,
    parameter logic [COLOR_W-1:0] BALL_COLOR  = 3'b010,
    parameter logic [COLOR_W-1:0] BG_COLOR    = 3'b000,
    parameter logic [COLOR_W-1:0] CODE_WALL   = 3'b001,
    parameter logic [COLOR_W-1:0] CODE_FLOOR  = 3'b010,
    parameter logic [COLOR_W-1:0] CODE_PADDLE = 3'b011
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         mode,
    output logic [X_W-1:0]     obs_x,
    output logic [Y_W-1:0]     obs_y,
    input  logic [COLOR_W-1:0] obs_code,
    output logic [X_W-1:0]     plot_x,
    output logic [Y_W-1:0]     plot_y,
    output logic [COLOR_W-1:0] color,
    output logic               plot_we,
    output logic [7:0]         score,
    output logic               game_over,
    output logic               busy
);

    localparam int K_W = (NUM_BALLS > 1) ? $clog2(NUM_BALLS) : 1;
    localparam int P_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
    localparam logic [COLOR_W-1:0] CODE_BLK_A = COLOR_W'(3'b100);
    localparam logic [COLOR_W-1:0] CODE_BLK_B = COLOR_W'(3'b110);
    localparam logic [COLOR_W-1:0] CODE_BLK_C = COLOR_W'(3'b111);

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_WAIT, S_ERASE, S_PV, S_RV, S_PH, S_RH, S_MOVE, S_DRAW, S_NEXT
    } state_t;

    state_t state, state_n;

    logic [X_W-1:0]       ball_x [NUM_BALLS];
    logic [Y_W-1:0]       ball_y [NUM_BALLS];
    logic [NUM_BALLS-1:0] xdir, ydir, alive;
    logic [K_W-1:0]       k;
    logic [TIMER_W-1:0]   timer, limit_sel;
    logic [P_W-1:0]       presc;
    logic [X_W-1:0]       ctr;

    logic [X_W-1:0] cur_x;
    logic [Y_W-1:0] cur_y;
    logic cur_xd, cur_yd, cur_alive;
    logic is_block, is_bounce, is_floor, last, any_alive, tick, all_dead;

    // Output-process results, registered by the datapath below
    logic               do_plot, obs_ld, hit;
    logic [X_W-1:0]     px_n, ox_n;
    logic [Y_W-1:0]     py_n, oy_n;
    logic [COLOR_W-1:0] pc_n;

    assign cur_x     = ball_x[k];
    assign cur_y     = ball_y[k];
    assign cur_xd    = xdir[k];
    assign cur_yd    = ydir[k];
    assign cur_alive = alive[k];
    assign is_block  = (obs_code == CODE_BLK_A) || (obs_code == CODE_BLK_B) || (obs_code == CODE_BLK_C);
    assign is_bounce = is_block || (obs_code == CODE_WALL) || (obs_code == CODE_PADDLE);
    assign is_floor  = (obs_code == CODE_FLOOR);
    assign last      = (k == K_W'(NUM_BALLS - 1));
    assign any_alive = |alive;
    assign tick      = (timer >= limit_sel);
    assign all_dead  = last && !any_alive &&
                       ((state == S_NEXT) || (state == S_ERASE && !cur_alive));
    assign busy      = (state != S_IDLE);

    always_comb begin
        case (mode)
            2'd0:    limit_sel = TIMER_W'(LIMIT0);
            2'd1:    limit_sel = TIMER_W'(LIMIT1);
            2'd2:    limit_sel = TIMER_W'(LIMIT2);
            default: limit_sel = TIMER_W'(LIMIT3);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  state_n = S_IDLE;
            S_INIT:  state_n = S_WAIT;
            S_WAIT:  if (tick) state_n = S_ERASE;
            S_ERASE: begin
                if (cur_alive) state_n = S_PV;
                else if (last) state_n = any_alive ? S_WAIT : S_IDLE;
                else           state_n = S_ERASE;
            end
            S_PV:    state_n = S_RV;
            S_RV:    state_n = is_floor ? S_NEXT : S_PH;
            S_PH:    state_n = S_RH;
            S_RH:    state_n = S_MOVE;
            S_MOVE:  state_n = S_DRAW;
            S_DRAW:  state_n = S_NEXT;
            S_NEXT:  begin
                if (last) state_n = any_alive ? S_WAIT : S_IDLE;
                else      state_n = S_ERASE;
            end
            default: state_n = S_IDLE;
        endcase
        if (start) state_n = S_INIT;
    end

    // Probe addresses are loaded one state early so the RAM's one-cycle read lands in RV/RH
    always_comb begin
        do_plot = 1'b0;
        obs_ld  = 1'b0;
        hit     = 1'b0;
        px_n    = cur_x;
        py_n    = cur_y;
        pc_n    = BG_COLOR;
        ox_n    = cur_x;
        oy_n    = cur_y;
        case (state)
            S_ERASE: begin
                do_plot = cur_alive;
                obs_ld  = cur_alive;
                oy_n    = cur_yd ? cur_y + 1'b1 : cur_y - 1'b1;
            end
            S_RV: begin
                obs_ld = !is_floor;
                ox_n   = cur_xd ? cur_x + 1'b1 : cur_x - 1'b1;
                hit    = is_block;
            end
            S_RH:   hit = is_block;
            S_DRAW: begin
                do_plot = 1'b1;
                pc_n    = BALL_COLOR;
            end
            default: ;
        endcase
        if (start) do_plot = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctr       <= X_W'(X_MIN);
            timer     <= '0;
            k         <= '0;
            presc     <= '0;
            score     <= '0;
            game_over <= 1'b0;
            alive     <= '0;
            xdir      <= '0;
            ydir      <= '0;
            plot_we   <= 1'b0;
            plot_x    <= '0;
            plot_y    <= '0;
            color     <= '0;
            obs_x     <= '0;
            obs_y     <= '0;
            for (int i = 0; i < NUM_BALLS; i++) begin
                ball_x[i] <= '0;
                ball_y[i] <= '0;
            end
        end else begin
            ctr     <= (ctr >= X_W'(X_MAX)) ? X_W'(X_MIN) : ctr + 1'b1;
            plot_we <= do_plot;
            if (do_plot) begin
                plot_x <= px_n;
                plot_y <= py_n;
                color  <= pc_n;
            end
            if (obs_ld) begin
                obs_x <= ox_n;
                obs_y <= oy_n;
            end
            if (hit) begin
                if (presc == P_W'(SCORE_DIV - 1)) begin
                    presc <= '0;
                    if (score != 8'hFF) score <= score + 8'd1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
            if (all_dead) game_over <= 1'b1;
            case (state)
                S_INIT: begin
                    for (int i = 0; i < NUM_BALLS; i++) begin
                        ball_x[i] <= ctr + X_W'(i * BALL_SPACING);
                        ball_y[i] <= Y_W'(START_Y);
                        xdir[i]   <= ~i[0];
                    end
                    ydir      <= '1;
                    alive     <= '1;
                    score     <= '0;
                    presc     <= '0;
                    game_over <= 1'b0;
                    timer     <= '0;
                end
                S_WAIT: begin
                    if (tick) begin
                        timer <= '0;
                        k     <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_ERASE: if (!cur_alive && !last) k <= k + 1'b1;
                S_RV: begin
                    if (is_floor)       alive[k] <= 1'b0;
                    else if (is_bounce) ydir[k]  <= ~cur_yd;
                end
                S_RH: if (is_bounce) xdir[k] <= ~cur_xd;
                S_MOVE: begin
                    ball_x[k] <= cur_xd ? cur_x + 1'b1 : cur_x - 1'b1;
                    ball_y[k] <= cur_yd ? cur_y + 1'b1 : cur_y - 1'b1;
                end
                S_NEXT: if (!last) k <= k + 1'b1;
                default: ;
            endcase
        end
    end

endmodule
